// File: rtl/mmio_bridge_if.sv
// LSU-side bus between the core, data RAM and the MMIO bridge.
// master drives requests; slave is the bridge.
interface mmio_bridge_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ld;
   logic        st;
   logic [1:0]  dw;
   logic [31:0] mem_read_data;
   logic        mem_en;
   logic [31:0] mem_read_mux;
   logic        stall;
   logic        err;

   modport master (
      output addr, wdata, ld, st, dw, mem_read_data,
      input  mem_en, mem_read_mux, stall, err
   );

   modport slave (
      input  addr, wdata, ld, st, dw, mem_read_data,
      output mem_en, mem_read_mux, stall, err
   );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO bridge: RAM pass-through plus a wait-stated IO register window
// with byte/half/word lanes, write-region readback and fault reporting.
module mmio_bridge #(
   parameter logic [31:0] IO_BASE     = 32'h0002_0000,
   parameter logic [31:0] IO_SIZE     = 32'h0002_0000,
   parameter int          N_RD_BYTES  = 64,
   parameter int          N_WR_BYTES  = 64,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   mmio_bridge_if.slave            bus,
   input  logic [8*N_RD_BYTES-1:0] io_r,
   output logic [8*N_WR_BYTES-1:0] io_w
);
   localparam int RI = $clog2(N_RD_BYTES);
   localparam int WI = $clog2(N_WR_BYTES);
   localparam logic [32:0] IO_END = {1'b0, IO_BASE} + {1'b0, IO_SIZE};
   localparam logic [31:0] HALF = IO_SIZE >> 1;
   localparam logic [31:0] NR = 32'(N_RD_BYTES);
   localparam logic [31:0] NW = 32'(N_WR_BYTES);
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt;
   logic [31:0] rd_q, rd_d;
   logic        err_q;
   logic        io_hit, wr_rgn, misal, oob, fault;
   logic [31:0] off, woff, ro, len, idx;
   logic [RI-1:0] ri;
   logic [WI-1:0] wi;

   assign io_hit = ({1'b0, bus.addr} >= {1'b0, IO_BASE})
                && ({1'b0, bus.addr} < IO_END)
                && (bus.ld | bus.st);
   assign off    = bus.addr - IO_BASE;
   assign wr_rgn = off >= HALF;
   assign woff   = off - HALF;
   assign ro     = wr_rgn ? woff : off;

   always_comb begin
      len = 32'd4;
      unique case (bus.dw)
         2'd0:    len = 32'd1;
         2'd1:    len = 32'd2;
         default: len = 32'd4;
      endcase
   end

   assign misal = ((bus.dw == 2'd1) && bus.addr[0])
               || ((bus.dw == 2'd2) && (bus.addr[1:0] != 2'b00));
   assign oob   = wr_rgn ? (woff + len > NW) : (off + len > NR);
   assign fault = (bus.dw == 2'd3) | misal | oob
               | (bus.st & ~wr_rgn) | (bus.ld & bus.st);

   // Gather up to four little-endian bytes; bytes above the width stay zero.
   always_comb begin
      rd_d = '0;
      idx  = '0;
      ri   = '0;
      wi   = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ro + 32'(i);
         ri  = RI'(idx);
         wi  = WI'(idx);
         if (32'(i) < len) begin
            if (wr_rgn && idx < NW)
               rd_d[8*i +: 8] = io_w[{wi, 3'b000} +: 8];
            else if (!wr_rgn && idx < NR)
               rd_d[8*i +: 8] = io_r[{ri, 3'b000} +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (io_hit) state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (cnt == 4'd0) state_n = RESP;
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         rd_q  <= '0;
         err_q <= 1'b0;
         io_w  <= '0;
      end else begin
         if (state == IDLE && io_hit)
            cnt <= CNT_INIT;
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         err_q <= 1'b0;
         if (state_n == RESP && state != RESP) begin
            rd_q  <= fault ? 32'd0 : rd_d;
            err_q <= fault;
         end
         // err_q holds this access's fault flag throughout RESP.
         if (state == RESP && bus.st && !err_q) begin
            for (int i = 0; i < 4; i++) begin
               if (32'(i) < len)
                  io_w[{woff[WI-1:0] + WI'(i), 3'b000} +: 8]
                     <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.mem_en       = !io_hit;
   assign bus.stall        = io_hit && (state != RESP) && !rst;
   assign bus.err          = err_q;
   assign bus.mem_read_mux = bus.mem_en ? bus.mem_read_data : rd_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge at WAIT_CYCLES 1 (default), 0 and 3,
// with a queue of expected responses popped at each RESP cycle.
module tb_mmio_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [511:0] io_r = '0;
   logic [511:0] w0, wz, w3;
   logic [511:0] m0 = '0;

   mmio_bridge_if b0();
   mmio_bridge_if bz();
   mmio_bridge_if b3();

   mmio_bridge u0 (.clk(clk), .rst(rst), .bus(b0), .io_r(io_r), .io_w(w0));
   mmio_bridge #(.WAIT_CYCLES(0)) uz (
      .clk(clk), .rst(rst), .bus(bz), .io_r(io_r), .io_w(wz));
   mmio_bridge #(.WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .bus(b3), .io_r(io_r), .io_w(w3));

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int sel = 0;

   logic        s_stall, s_err, s_en;
   logic [31:0] s_mux;

   always_comb begin
      s_stall = b0.stall;
      s_err   = b0.err;
      s_en    = b0.mem_en;
      s_mux   = b0.mem_read_mux;
      case (sel)
         1: begin
            s_stall = bz.stall; s_err = bz.err;
            s_en = bz.mem_en; s_mux = bz.mem_read_mux;
         end
         2: begin
            s_stall = b3.stall; s_err = b3.err;
            s_en = b3.mem_en; s_mux = b3.mem_read_mux;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic [31:0] a,
                        input logic [31:0] wd, input logic l,
                        input logic s, input logic [1:0] w);
      case (d)
         1: begin
            bz.addr = a; bz.wdata = wd; bz.ld = l; bz.st = s; bz.dw = w;
         end
         2: begin
            b3.addr = a; b3.wdata = wd; b3.ld = l; b3.st = s; b3.dw = w;
         end
         default: begin
            b0.addr = a; b0.wdata = wd; b0.ld = l; b0.st = s; b0.dw = w;
         end
      endcase
   endtask

   // Reference write model for u0: little-endian bytes at woff.
   task automatic model_st(input logic [31:0] a, input logic [31:0] wd,
                           input int n);
      int wo;
      wo = int'(a - 32'h0003_0000);
      for (int i = 0; i < n; i++)
         m0[8*(wo+i) +: 8] = wd[8*i +: 8];
   endtask

   task automatic access(input int d, input logic [31:0] a,
                         input logic [31:0] wd, input logic l,
                         input logic s, input logic [1:0] w,
                         input int cyc, input logic [31:0] data,
                         input logic e_err, input string tag);
      exp_t e;
      int   n;
      sb.push_back('{data, e_err, cyc});
      sel = d;
      drive(d, a, wd, l, s, w);
      #1;
      n = 0;
      while (s_stall && n < 40) begin
         n++;
         @(posedge clk);
         #2;
      end
      e = sb.pop_front();
      chk({tag, "_stall"}, 512'(n), 512'(e.cyc));
      chk({tag, "_en"}, 512'(s_en), 512'(1'b0));
      chk({tag, "_err"}, 512'(s_err), 512'(e.err));
      if (l) chk({tag, "_data"}, 512'(s_mux), 512'(e.data));
      @(posedge clk);
      #1;
      drive(d, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      #1;
      chk({tag, "_errclr"}, 512'(s_err), 512'(1'b0));
   endtask

   initial begin
      exp_t e;
      drive(1, 0, 0, 0, 0, 0);
      drive(2, 0, 0, 0, 0, 0);
      b0.mem_read_data = '0;
      bz.mem_read_data = '0;
      b3.mem_read_data = '0;
      drive(0, 32'h0002_0000, 0, 1'b1, 1'b0, 2'd2);
      repeat (2) @(posedge clk);
      #2;
      chk("rst_stall", 512'(s_stall), 512'(1'b0));
      chk("rst_iow", w0, '0);
      chk("rst_err", 512'(s_err), 512'(1'b0));
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // RAM pass-through
      sb.push_back('{32'h1234_5678, 1'b0, 0});
      b0.mem_read_data = 32'h1234_5678;
      drive(0, 32'h100, 0, 1'b1, 1'b0, 2'd2);
      #1;
      e = sb.pop_front();
      chk("ram_en", 512'(s_en), 512'(1'b1));
      chk("ram_stall", 512'(s_stall), 512'(1'b0));
      chk("ram_data", 512'(s_mux), 512'(e.data));
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // stores
      access(0, 32'h30004, 32'hDEAD_BEEF, 0, 1, 2, 2, 0, 0, "st_w");
      model_st(32'h30004, 32'hDEAD_BEEF, 4);
      chk("st_w_val", 512'(w0[63:32]), 512'(32'hDEAD_BEEF));
      access(0, 32'h30005, 32'h0000_00AB, 0, 1, 0, 2, 0, 0, "st_b");
      model_st(32'h30005, 32'hAB, 1);
      chk("st_b_val", 512'(w0[63:32]), 512'(32'hDEAD_ABEF));
      chk("st_b_all", w0, m0);
      access(0, 32'h3003E, 32'h0000_7733, 0, 1, 1, 2, 0, 0, "st_top");
      model_st(32'h3003E, 32'h7733, 2);
      chk("st_top_all", w0, m0);

      // reads
      io_r[31:0] = 32'hCAFE_F00D;
      io_r[511:504] = 8'h5A;
      access(0, 32'h20002, 0, 1, 0, 1, 2, 32'h0000_CAFE, 0, "ld_h");
      access(0, 32'h20000, 0, 1, 0, 0, 2, 32'h0000_000D, 0, "ld_b");
      access(0, 32'h30004, 0, 1, 0, 2, 2, 32'hDEAD_ABEF, 0, "ld_rb");
      access(0, 32'h2003C, 0, 1, 0, 2, 2, 32'h5A00_0000, 0, "ld_end");
      access(0, 32'h3003E, 0, 1, 0, 1, 2, 32'h0000_7733, 0, "ld_rbtop");

      // faults
      access(0, 32'h30006, 32'h1111_2222, 0, 1, 2, 2, 0, 1, "f_mis");
      chk("f_mis_iow", w0, m0);
      access(0, 32'h20000, 32'h5555_5555, 0, 1, 2, 2, 0, 1, "f_rost");
      access(0, 32'h20040, 0, 1, 0, 0, 2, 32'h0, 1, "f_oob");
      access(0, 32'h2003E, 0, 1, 0, 2, 2, 32'h0, 1, "f_misld");
      access(0, 32'h20000, 0, 1, 0, 3, 2, 32'h0, 1, "f_dw3");
      access(0, 32'h30004, 32'h9999_9999, 1, 1, 2, 2, 32'h0, 1, "f_ldst");
      access(0, 32'h3003F, 32'h4444, 0, 1, 1, 2, 0, 1, "f_wroob");
      chk("f_iow", w0, m0);

      // wait-state variants, back-to-back stores
      access(1, 32'h30000, 32'h55, 0, 1, 0, 1, 0, 0, "w0_a");
      access(1, 32'h30001, 32'h66, 0, 1, 0, 1, 0, 0, "w0_b");
      chk("w0_val", 512'(wz[15:0]), 512'(16'h6655));
      access(2, 32'h30000, 32'h55, 0, 1, 0, 4, 0, 0, "w3_a");
      access(2, 32'h30001, 32'h66, 0, 1, 0, 4, 0, 0, "w3_b");
      chk("w3_val", 512'(w3[15:0]), 512'(16'h6655));
      access(2, 32'h30000, 0, 1, 0, 1, 4, 32'h6655, 0, "w3_rd");

      // reset during WAIT drops the pending store
      sel = 0;
      drive(0, 32'h30000, 32'h11, 0, 1, 0);
      @(posedge clk);
      #2;
      chk("rw_stall", 512'(s_stall), 512'(1'b1));
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rw_stall0", 512'(s_stall), 512'(1'b0));
      chk("rw_iow", w0, '0);
      chk("rw_err", 512'(s_err), 512'(1'b0));
      m0 = '0;
      @(posedge clk);
      #2;
      chk("rw_iow2", w0, m0);
      access(0, 32'h30000, 0, 1, 0, 2, 2, 32'h0, 0, "rw_ld");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
